// File: rtl/rtc_alarm_timer.sv
// Memory-mapped real-time clock: Unix-seconds counter driven by an exact
// CLOCK_FREQ-cycle prescaler, run/stop control and N_ALARMS sticky alarms.
module rtc_alarm_timer #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned N_ALARMS   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic [1:0]  sel_i,
    input  logic        rd_i,
    input  logic        we_i,
    output logic        ack_o,
    output logic        irq_o
);

    localparam logic [31:0] PHASE_LAST = 32'(CLOCK_FREQ - 1);

    logic [31:0]         time_reg, time_next;
    logic [31:0]         phase_reg, phase_next;
    logic                run_reg, run_next;
    logic [N_ALARMS-1:0] irq_en_reg, irq_en_next;
    logic [N_ALARMS-1:0] status_reg, status_next;
    logic [31:0]         alarm_reg  [N_ALARMS];
    logic [31:0]         alarm_next [N_ALARMS];

    logic [2:0] idx;
    logic       wr_time, wr_ctrl, wr_status, tick;
    logic       unused_inputs;

    assign idx       = addr_i[4:2];
    assign wr_time   = we_i && (idx == 3'd0);
    assign wr_ctrl   = we_i && (idx == 3'd2);
    assign wr_status = we_i && (idx == 3'd3);

    // run_reg is the value before any CTRL write this cycle, so a stop
    // written in a tick cycle still lets that tick complete.
    assign tick = run_reg && (phase_reg == PHASE_LAST);

    assign ack_o         = 1'b1;
    assign irq_o         = |(status_reg & irq_en_reg);
    assign unused_inputs = &{1'b0, sel_i, rd_i, addr_i[31:5], addr_i[1:0]};

    always_comb begin
        time_next  = time_reg;
        phase_next = phase_reg;
        if (wr_time) begin
            time_next  = data_i;
            phase_next = '0;
        end else if (run_reg) begin
            if (tick) begin
                time_next  = time_reg + 32'd1;
                phase_next = '0;
            end else begin
                phase_next = phase_reg + 32'd1;
            end
        end
    end

    assign run_next    = wr_ctrl ? data_i[0] : run_reg;
    assign irq_en_next = wr_ctrl ? data_i[N_ALARMS:1] : irq_en_reg;

    genvar gi;
    generate
        for (gi = 0; gi < int'(N_ALARMS); gi++) begin : g_alarm
            logic wr_alarm, hit;
            assign wr_alarm = we_i && (idx == 3'(4 + gi));
            // Compare against the old alarm value and the incremented time;
            // a TIME write in the same cycle discards the tick entirely.
            assign hit = tick && !wr_time && (alarm_reg[gi] == time_reg + 32'd1);
            assign alarm_next[gi]  = wr_alarm ? data_i : alarm_reg[gi];
            assign status_next[gi] = hit | (status_reg[gi] & ~(wr_status & data_i[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            time_reg   <= '0;
            phase_reg  <= '0;
            run_reg    <= 1'b1;
            irq_en_reg <= '0;
            status_reg <= '0;
            for (int k = 0; k < int'(N_ALARMS); k++) begin
                alarm_reg[k] <= 32'hFFFF_FFFF;
            end
        end else begin
            time_reg   <= time_next;
            phase_reg  <= phase_next;
            run_reg    <= run_next;
            irq_en_reg <= irq_en_next;
            status_reg <= status_next;
            for (int k = 0; k < int'(N_ALARMS); k++) begin
                alarm_reg[k] <= alarm_next[k];
            end
        end
    end

    always_comb begin
        data_o = '0;
        case (idx)
            3'd0: data_o = time_reg;
            3'd1: data_o = phase_reg;
            3'd2: data_o = 32'({irq_en_reg, run_reg});
            3'd3: data_o = 32'(status_reg);
            default: begin
                for (int k = 0; k < int'(N_ALARMS); k++) begin
                    if (idx == 3'(4 + k)) begin
                        data_o = alarm_reg[k];
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_alarm_timer.sv
// Self-checking bench for rtc_alarm_timer (CLOCK_FREQ=10, N_ALARMS=2):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_rtc_alarm_timer;

    localparam int unsigned CF = 10;
    localparam int unsigned NA = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i, data_i, data_o;
    logic [1:0]  sel_i;
    logic        rd_i, we_i, ack_o, irq_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] obs;
    logic        obs_irq;

    // Behavioural model state
    int unsigned m_time, m_phase;
    bit          m_run;
    bit [NA-1:0] m_irqen, m_status;
    logic [31:0] m_alarm [NA];

    rtc_alarm_timer #(.CLOCK_FREQ(CF), .N_ALARMS(NA)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_o(data_o), .data_i(data_i),
        .sel_i(sel_i), .rd_i(rd_i), .we_i(we_i), .ack_o(ack_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return m_time;
            3'd1: return m_phase;
            3'd2: return {29'b0, m_irqen, m_run};
            3'd3: return {30'b0, m_status};
            3'd4: return m_alarm[0];
            3'd5: return m_alarm[1];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_irq();
        return |(m_status & m_irqen);
    endfunction

    task automatic model_reset();
        m_time = 0; m_phase = 0; m_run = 1'b1; m_irqen = '0; m_status = '0;
        for (int k = 0; k < int'(NA); k++) m_alarm[k] = 32'hFFFF_FFFF;
    endtask

    // One rising edge of the model, applying the register rules directly.
    task automatic model_edge(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        bit          tick;
        bit [NA-1:0] st;
        if (r) begin
            model_reset();
            return;
        end
        tick = m_run && (m_phase == CF - 1);
        st = m_status;
        if (w && a == 3'd3) st = st & ~d[NA-1:0];
        if (w && a == 3'd0) begin
            m_time = d;
            m_phase = 0;
        end else if (m_run) begin
            m_phase = (m_phase + 1) % CF;
            if (tick) begin
                m_time = m_time + 1;
                for (int k = 0; k < int'(NA); k++)
                    if (m_alarm[k] == m_time) st[k] = 1'b1;
            end
        end
        if (w && a == 3'd2) begin
            m_run = d[0];
            m_irqen = d[NA:1];
        end
        if (w && a == 3'd4) m_alarm[0] = d;
        if (w && a == 3'd5) m_alarm[1] = d;
        m_status = st;
    endtask

    // Present one bus cycle; outputs are checked at the falling edge.
    task automatic step(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        logic [31:0] rnd;
        rnd = $urandom();
        rst = r; we_i = w; rd_i = ~w; data_i = d;
        addr_i = {rnd[31:5], a, rnd[1:0]};
        sel_i = rnd[4:3];
        @(negedge clk);
        obs = data_o;
        obs_irq = irq_o;
        check_eq($sformatf("data_o[%0d]", a), data_o, model_read(a));
        check_eq("irq_o", {31'b0, irq_o}, {31'b0, model_irq()});
        check_eq("ack_o", {31'b0, ack_o}, 32'd1);
        @(posedge clk);
        model_edge(r, w, a, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'($urandom_range(0, 7)), 32'h0);
    endtask

    task automatic rd_expect(input logic [2:0] a, input logic [31:0] exp, input string tag);
        step(1'b0, 1'b0, a, 32'h0);
        check_eq(tag, obs, exp);
    endtask

    task automatic wait_phase(input int unsigned p);
        for (int i = 0; i < 30 && m_phase != p; i++) step(1'b0, 1'b0, 3'd1, 32'h0);
    endtask

    initial begin
        int unsigned t_hold;
        int          n;
        logic [31:0] lv;
        rst = 1'b1; we_i = 1'b0; rd_i = 1'b0; addr_i = '0; data_i = '0; sel_i = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state, read while rst is held
        for (int a = 0; a < 8; a++) begin
            lv = (a == 2) ? 32'h1 : (a == 4 || a == 5) ? 32'hFFFF_FFFF : 32'h0;
            step(1'b1, 1'b0, 3'(a), 32'h0);
            check_eq($sformatf("reset_reg%0d", a), obs, lv);
        end

        // 1: prescaler from reset
        idle(10);
        rd_expect(3'd1, 32'd0, "t1_phase10");
        rd_expect(3'd0, 32'd1, "t1_time10");
        idle(23);
        rd_expect(3'd1, 32'd5, "t1_phase35");
        rd_expect(3'd0, 32'd3, "t1_time35");

        // 2: TIME wrap
        step(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF);
        idle(10);
        rd_expect(3'd0, 32'd0, "t2_time_wrap");
        rd_expect(3'd3, 32'd0, "t2_status");
        check_eq("t2_irq", {31'b0, obs_irq}, 32'd0);

        // 3: alarm 0 fires and W1C clears it
        step(1'b0, 1'b1, 3'd4, 32'd5);
        step(1'b0, 1'b1, 3'd2, 32'h3);
        step(1'b0, 1'b1, 3'd0, 32'd0);
        idle(49);
        rd_expect(3'd3, 32'd0, "t3_status_before");
        rd_expect(3'd3, 32'd1, "t3_status_fired");
        check_eq("t3_irq_fired", {31'b0, obs_irq}, 32'd1);
        step(1'b0, 1'b1, 3'd3, 32'h1);
        rd_expect(3'd3, 32'd0, "t3_status_cleared");
        check_eq("t3_irq_cleared", {31'b0, obs_irq}, 32'd0);

        // 4: write-created match never fires; set beats W1C
        step(1'b0, 1'b1, 3'd5, m_time);
        rd_expect(3'd3, 32'd0, "t4_no_write_fire");
        for (int i = 0; i < 5 && m_phase >= 8; i++) idle(1);
        step(1'b0, 1'b1, 3'd4, m_time + 1);
        wait_phase(9);
        step(1'b0, 1'b1, 3'd3, 32'h1);
        rd_expect(3'd3, 32'd1, "t4_set_wins");
        step(1'b0, 1'b1, 3'd3, 32'h3);

        // 5: stop and resume
        wait_phase(4);
        step(1'b0, 1'b1, 3'd2, 32'h0);
        t_hold = m_time;
        idle(20);
        rd_expect(3'd0, t_hold, "t5_time_held");
        rd_expect(3'd1, 32'd5, "t5_phase_held");
        step(1'b0, 1'b1, 3'd2, 32'h1);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 3'd0, 32'h0);
            if (obs != t_hold) break;
            n++;
        end
        check_eq("t5_resume_edges", n, 32'd6);

        // 6: TIME write at PHASE=9, then reset during a write
        wait_phase(9);
        step(1'b0, 1'b1, 3'd0, 32'h1234_5678);
        rd_expect(3'd0, 32'h1234_5678, "t6_time_write");
        rd_expect(3'd1, 32'd1, "t6_phase_restart");
        step(1'b0, 1'b1, 3'd4, 32'd7);
        step(1'b1, 1'b1, 3'd4, 32'h55);
        rd_expect(3'd4, 32'hFFFF_FFFF, "t6_rst_alarm");
        rd_expect(3'd2, 32'h1, "t6_rst_ctrl");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, w;
            logic [2:0]  a;
            logic [31:0] d;
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 3) == 0);
            a = 3'($urandom_range(0, 7));
            d = $urandom();
            if (w && a == 3'd0 && $urandom_range(0, 7) != 0) w = 1'b0;
            if (a == 3'd4 || a == 3'd5) d = m_time + $urandom_range(0, 3);
            if (a == 3'd2) d[0] = ($urandom_range(0, 3) != 0);
            step(r, w, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_alarm_timer.md
# rtc_alarm_timer

Memory-mapped real-time clock with a Unix-seconds counter and N_ALARMS compare channels, each able to raise a level interrupt. It sits on the same simple peripheral bus as the other system-on-chip slaves (single-cycle ack, word registers) and is the successor to the plain seconds counter. Over that counter it adds:
- an exact CLOCK_FREQ-cycle second,
- a run/stop control,
- a readable sub-second phase,
- alarm channels with sticky status and interrupt.

## Interface
Parameters:
- CLOCK_FREQ, 100_000_000: input clock cycles per second; legal range 2 to 2^32-1.
- N_ALARMS, 2: number of alarm compare channels; legal range 1 to 4.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- addr_i  input  32  byte address; addr_i[4:2] selects the register; other bits ignored.
- data_o  output  32  read data; combinational mux of the selected register, valid whenever addressed.
- data_i  input  32  write data.
- sel_i  input  2  access-size select; ignored; all accesses are full 32-bit words.
- rd_i  input  1  read strobe; reads have no side effects.
- we_i  input  1  write strobe; write takes effect at the next rising clk.
- ack_o  output  1  constant 1; every access completes in the cycle it is presented.
- irq_o  output  1  level interrupt: |(STATUS & CTRL.irq_en); combinational from registers.

## Operation
Register map (word index = addr_i[4:2]):
- 0 TIME, R/W: Unix seconds.
- 1 PHASE, RO: prescaler count, 0..CLOCK_FREQ-1.
- 2 CTRL, R/W: bit0 run; bits[N_ALARMS:1] irq_en per alarm. Other bits read 0.
- 3 STATUS, R/W1C: bits[N_ALARMS-1:0] alarm pending. Writing 1 clears a bit; writing 0 has no effect.
- 4..4+N_ALARMS-1 ALARMk, R/W: compare seconds for alarm k.
- Unimplemented indices read 0; writes to them are ignored.

Reset values: TIME=0, PHASE=0, CTRL=0x1 (running, all irqs disabled), STATUS=0, ALARMk=0xFFFFFFFF, irq_o=0, data_o=mux of reset values. rst overrides any write in the same cycle.

Prescaler:
- When CTRL.run=1, PHASE increments by 1 each cycle.
- At PHASE==CLOCK_FREQ-1, PHASE wraps to 0 and a tick is generated. Exactly one tick every CLOCK_FREQ cycles.
- When CTRL.run=0, PHASE and TIME hold and no ticks occur.

Tick:
- TIME <= TIME+1, wrapping modulo 2^32 (0xFFFFFFFF -> 0).
- For each k with ALARMk == TIME+1 (the new value), STATUS[k] <= 1.
- Alarms fire only on ticks. A match created by a TIME or ALARMk write never fires.

TIME write:
- TIME <= data_i and PHASE <= 0.
- Any tick due that cycle is discarded: no increment, no alarm set.

Simultaneous events:
- Alarm set and W1C clear of the same STATUS bit in one cycle: set wins, bit stays 1.
- ALARMk write in a tick cycle: the compare uses the old ALARMk value.
- CTRL write clearing run in a tick cycle: that tick still completes.

## Timing
- Writes: registered value visible on data_o from the cycle after the we_i edge.
- Reads: zero latency.
- Tick at the edge ending the cycle where PHASE==CLOCK_FREQ-1 with run=1. TIME and STATUS update on that edge; irq_o rises combinationally in the following cycle when enabled.
- After rst deasserts, the first tick occurs exactly CLOCK_FREQ cycles later.
- After a TIME write edge, the next tick occurs CLOCK_FREQ cycles later.
- Stop/start: the phase resumes from the held PHASE value; no cycles are lost or gained.

## Test plan
Test with CLOCK_FREQ=10, N_ALARMS=2.
1. Reset, run 10 cycles -> TIME=1 after the 10th edge, PHASE=0. After 35 cycles -> TIME=3, PHASE=5.
2. Write TIME=0xFFFFFFFF, wait 10 cycles -> TIME=0, no spurious alarm, irq_o=0.
3. Write ALARM0=5 and CTRL=0x3, run from TIME=0 -> STATUS=0x1 and irq_o=1 on the tick to 5. W1C STATUS=0x1 -> irq_o=0.
4. Write ALARM1 equal to the current TIME -> STATUS stays 0. Issue a W1C to STATUS bit 0 in the same cycle as alarm 0 fires -> STATUS[0]=1.
5. At PHASE=4, write CTRL=0x0, wait 20 cycles -> TIME and PHASE unchanged. Write CTRL=0x1 -> tick after exactly 6 more cycles.
6. Issue a TIME write in the cycle where PHASE=9 -> TIME=data_i, PHASE=0, no increment. Assert rst during a write -> all registers take their reset values.
